// File: rtl/gonsolo_gpio_pkg.sv
// rtl/gonsolo_gpio_pkg.sv - register offsets, field widths and interrupt encodings for gonsolo_gpio
package gonsolo_gpio_pkg;

    localparam logic [4:0] OFF_DATA_OUT   = 5'h00;
    localparam logic [4:0] OFF_OEB        = 5'h04;
    localparam logic [4:0] OFF_DATA_IN    = 5'h08;
    localparam logic [4:0] OFF_IRQ_EN     = 5'h0C;
    localparam logic [4:0] OFF_IRQ_TYPE   = 5'h10;
    localparam logic [4:0] OFF_IRQ_POL    = 5'h14;
    localparam logic [4:0] OFF_IRQ_STATUS = 5'h18;
    localparam logic [4:0] OFF_IRQ_ROUTE  = 5'h1C;

    localparam int ROUTE_W = 2;

    typedef enum logic {IRQ_EDGE = 1'b0, IRQ_LEVEL = 1'b1} irq_type_e;
    typedef enum logic {POL_HIGH = 1'b0, POL_LOW = 1'b1} irq_pol_e;

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        for (int b = 0; b < 4; b++) sel_mask[8*b +: 8] = {8{sel[b]}};
    endfunction

endpackage

// File: rtl/gonsolo_gpio_if.sv
// rtl/gonsolo_gpio_if.sv - Wishbone slave bus bundle for gonsolo_gpio
interface gonsolo_gpio_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/gonsolo_gpio_sync.sv
// rtl/gonsolo_gpio_sync.sv - one pin's synchroniser, history flop and interrupt event detect
module gonsolo_gpio_sync
    import gonsolo_gpio_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic pad,
    input  logic irq_type,
    input  logic irq_pol,
    output logic sync,
    output logic pin_event
);
    logic s1, s2, prev, active;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= pad;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Active when the synchronised level is the inverse of the polarity bit.
    assign active    = (s2 != irq_pol);
    assign sync      = s2;
    assign pin_event = (irq_type == IRQ_LEVEL) ? active : (active && (s2 != prev));

endmodule

// File: rtl/gonsolo_gpio.sv
// rtl/gonsolo_gpio.sv - Wishbone GPIO and interrupt controller with per-pin IRQ routing
module gonsolo_gpio
    import gonsolo_gpio_pkg::*;
#(
    parameter int          NUM_PADS  = 16,
    parameter int          IRQ_LINES = 3,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    gonsolo_gpio_if.slave        wb,
    input  logic [NUM_PADS-1:0]  io_in,
    output logic [NUM_PADS-1:0]  io_out,
    output logic [NUM_PADS-1:0]  io_oeb,
    output logic [IRQ_LINES-1:0] irq
);
    localparam int RW = ROUTE_W * NUM_PADS;

    logic [NUM_PADS-1:0]  data_out, oeb, irq_en, irq_type, irq_pol, irq_status;
    logic [NUM_PADS-1:0]  data_in, pin_event, pmask, pdat, w1c;
    logic [RW-1:0]        irq_route, rmask, rdat;
    logic [IRQ_LINES-1:0] irq_next;
    logic [31:0]          wmask, rdata;
    logic [4:0]           off;
    logic                 hit, req, wr;

    assign hit   = (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    // Blocking on ack spaces a held strobe out to one ack every two cycles.
    assign req   = wb.wbs_stb_i & wb.wbs_cyc_i & hit & ~wb.wbs_ack_o;
    assign wr    = req & wb.wbs_we_i;
    assign off   = {wb.wbs_adr_i[4:2], 2'b00};
    assign wmask = sel_mask(wb.wbs_sel_i);
    assign pmask = wmask[NUM_PADS-1:0];
    assign pdat  = wb.wbs_dat_i[NUM_PADS-1:0];
    assign rmask = wmask[RW-1:0];
    assign rdat  = wb.wbs_dat_i[RW-1:0];
    assign w1c   = (wr && off == OFF_IRQ_STATUS) ? (pdat & pmask) : '0;

    assign io_out = data_out;
    assign io_oeb = oeb;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pin
        gonsolo_gpio_sync u_sync (
            .clock     (clock),
            .reset_n   (reset_n),
            .pad       (io_in[p]),
            .irq_type  (irq_type[p]),
            .irq_pol   (irq_pol[p]),
            .sync      (data_in[p]),
            .pin_event (pin_event[p])
        );
    end

    always_comb begin
        rdata = '0;
        case (off)
            OFF_DATA_OUT:   rdata = 32'(data_out);
            OFF_OEB:        rdata = 32'(oeb);
            OFF_DATA_IN:    rdata = 32'(data_in);
            OFF_IRQ_EN:     rdata = 32'(irq_en);
            OFF_IRQ_TYPE:   rdata = 32'(irq_type);
            OFF_IRQ_POL:    rdata = 32'(irq_pol);
            OFF_IRQ_STATUS: rdata = 32'(irq_status);
            OFF_IRQ_ROUTE:  rdata = 32'(irq_route);
            default:        rdata = '0;
        endcase
    end

    // Route codes at or above IRQ_LINES never match a line index, so those pins route nowhere.
    always_comb begin
        irq_next = '0;
        for (int k = 0; k < IRQ_LINES; k++) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                if (irq_route[ROUTE_W*p +: ROUTE_W] == ROUTE_W'(k))
                    irq_next[k] = irq_next[k] | (irq_status[p] & irq_en[p]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out     <= '0;
            oeb          <= '1;
            irq_en       <= '0;
            irq_type     <= '0;
            irq_pol      <= '0;
            irq_status   <= '0;
            irq_route    <= '0;
            irq          <= '0;
            wb.wbs_ack_o <= 1'b0;
            wb.wbs_dat_o <= '0;
        end else begin
            wb.wbs_ack_o <= req;
            wb.wbs_dat_o <= req ? rdata : '0;
            irq          <= irq_next;
            // A new event wins over a same-cycle write-one-to-clear.
            irq_status   <= (irq_status & ~w1c) | pin_event;
            if (wr) begin
                case (off)
                    OFF_DATA_OUT:  data_out  <= (data_out  & ~pmask) | (pdat & pmask);
                    OFF_OEB:       oeb       <= (oeb       & ~pmask) | (pdat & pmask);
                    OFF_IRQ_EN:    irq_en    <= (irq_en    & ~pmask) | (pdat & pmask);
                    OFF_IRQ_TYPE:  irq_type  <= (irq_type  & ~pmask) | (pdat & pmask);
                    OFF_IRQ_POL:   irq_pol   <= (irq_pol   & ~pmask) | (pdat & pmask);
                    OFF_IRQ_ROUTE: irq_route <= (irq_route & ~rmask) | (rdat & rmask);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gonsolo_gpio.sv
// tb/tb_gonsolo_gpio.sv - self-checking bench for gonsolo_gpio
module tb_gonsolo_gpio;
    import gonsolo_gpio_pkg::*;

    localparam int          NP   = 16;
    localparam int          NL   = 3;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [NP-1:0] io_in, io_out, io_oeb;
    logic [NL-1:0] irq;

    gonsolo_gpio_if bus ();

    gonsolo_gpio #(.NUM_PADS(NP), .IRQ_LINES(NL), .BASE_ADDR(BASE)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .wb      (bus.slave),
        .io_in   (io_in),
        .io_out  (io_out),
        .io_oeb  (io_oeb),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [15:0] m_data_out, m_oeb, m_en, m_type, m_pol, m_status, m_pad;
    logic [31:0] m_route;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data_out = '0; m_oeb = 16'hFFFF; m_en = '0; m_type = '0;
        m_pol = '0; m_status = '0; m_route = '0; m_pad = io_in;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] off);
        case (off)
            OFF_DATA_OUT:   return {16'h0, m_data_out};
            OFF_OEB:        return {16'h0, m_oeb};
            OFF_DATA_IN:    return {16'h0, m_pad};
            OFF_IRQ_EN:     return {16'h0, m_en};
            OFF_IRQ_TYPE:   return {16'h0, m_type};
            OFF_IRQ_POL:    return {16'h0, m_pol};
            OFF_IRQ_STATUS: return {16'h0, m_status};
            OFF_IRQ_ROUTE:  return m_route;
            default:        return 32'h0;
        endcase
    endfunction

    function automatic logic [2:0] m_irq();
        logic [2:0] r = '0;
        logic [1:0] line;
        for (int p = 0; p < NP; p++) begin
            line = m_route[2*p +: 2];
            if (m_status[p] && m_en[p] && line < 2'd3) r[line] = 1'b1;
        end
        return r;
    endfunction

    task automatic wb(input logic w, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output logic acked);
        @(negedge clock);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = w;
        bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
        acked = 1'b0; rd = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clock); #1;
            if (bus.wbs_ack_o) begin acked = 1'b1; rd = bus.wbs_dat_o; end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d, mask, md;
        logic a;
        wb(1'b1, BASE + 32'(off), dat, sel, d, a);
        check("wr_ack", 32'(a), 32'h1);
        mask = '0;
        for (int b = 0; b < 4; b++) if (sel[b]) mask[8*b +: 8] = 8'hFF;
        md = dat & mask;
        case (off)
            OFF_DATA_OUT:   m_data_out = (m_data_out & ~mask[15:0]) | md[15:0];
            OFF_OEB:        m_oeb      = (m_oeb      & ~mask[15:0]) | md[15:0];
            OFF_IRQ_EN:     m_en       = (m_en       & ~mask[15:0]) | md[15:0];
            OFF_IRQ_TYPE:   m_type     = (m_type     & ~mask[15:0]) | md[15:0];
            OFF_IRQ_POL:    m_pol      = (m_pol      & ~mask[15:0]) | md[15:0];
            OFF_IRQ_STATUS: m_status   = m_status & ~md[15:0];
            OFF_IRQ_ROUTE:  m_route    = (m_route & ~mask) | md;
            default: ;
        endcase
        // level pins at their active level keep their status bit set
        m_status = m_status | (m_type & (m_pad ^ m_pol));
    endtask

    task automatic rd_chk(input logic [4:0] off, input string tag);
        logic [31:0] d;
        logic a;
        repeat (2) @(negedge clock);
        wb(1'b0, BASE + 32'(off), 32'h0, 4'hF, d, a);
        check({tag, "_ack"}, 32'(a), 32'h1);
        check(tag, d, m_read(off));
    endtask

    task automatic set_pads(input logic [15:0] nv);
        @(negedge clock);
        io_in = nv;
        m_status = m_status | (~m_type & (nv ^ m_pad) & (nv ^ m_pol)) | (m_type & (nv ^ m_pol));
        m_pad = nv;
        repeat (4) @(negedge clock);
    endtask

    task automatic check_irq(input string tag);
        repeat (2) @(negedge clock);
        check(tag, 32'(irq), 32'(m_irq()));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic a;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        io_in = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        model_reset();

        // reset state
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_io_oeb", 32'(io_oeb), 32'h0000FFFF);
        check("rst_io_out", 32'(io_out), 32'h0);
        for (int i = 0; i < 8; i++) rd_chk(5'(4 * i), "rst_rd");

        // byte-enabled write
        wb(1'b1, BASE + 32'(OFF_DATA_OUT), 32'hA5A5, 4'b0001, d, a);
        check("a5_ack", 32'(a), 32'h1);
        check("a5_io_out", 32'(io_out), 32'h00A5);
        m_data_out = 16'h00A5;
        rd_chk(OFF_DATA_OUT, "a5_rd");

        // rising edge on pin 3 routed to line 2, cycle-exact latency
        wr(OFF_IRQ_EN, 32'h8, 4'hF);
        wr(OFF_IRQ_ROUTE, 32'h80, 4'hF);
        repeat (2) @(negedge clock);
        io_in[3] = 1'b1;
        m_pad = io_in; m_status[3] = 1'b1;
        repeat (3) @(negedge clock);
        check("edge_irq_t2", 32'(irq), 32'h0);
        @(negedge clock);
        check("edge_irq_t3", 32'(irq), 32'h4);
        rd_chk(OFF_IRQ_STATUS, "edge_status");
        rd_chk(OFF_DATA_IN, "edge_din");
        wr(OFF_IRQ_STATUS, 32'h8, 4'hF);
        check_irq("edge_w1c_irq");
        check("edge_w1c_irq0", 32'(irq), 32'h0);

        // pin 5 level-low
        wr(OFF_IRQ_TYPE, 32'h20, 4'hF);
        wr(OFF_IRQ_POL, 32'h20, 4'hF);
        wr(OFF_IRQ_EN, 32'h28, 4'hF);
        wr(OFF_IRQ_STATUS, 32'h20, 4'hF);
        rd_chk(OFF_IRQ_STATUS, "level_hold");
        check_irq("level_irq");
        check("level_irq1", 32'(irq), 32'h1);
        set_pads(m_pad | 16'h0020);
        wr(OFF_IRQ_STATUS, 32'h20, 4'hF);
        rd_chk(OFF_IRQ_STATUS, "level_clr");
        check_irq("level_irq_off");

        // edge on pin 2 in the same cycle as its W1C
        set_pads(m_pad | 16'h0004);
        set_pads(m_pad & ~16'h0004);
        @(negedge clock);
        io_in[2] = 1'b1;
        m_pad = io_in;
        @(negedge clock);
        wb(1'b1, BASE + 32'(OFF_IRQ_STATUS), 32'h4, 4'hF, d, a);
        check("coinc_ack", 32'(a), 32'h1);
        rd_chk(OFF_IRQ_STATUS, "coinc_status");

        // outside the window
        wb(1'b1, BASE + 32'h40, 32'hFFFF, 4'hF, d, a);
        check("oow_noack", 32'(a), 32'h0);
        rd_chk(OFF_DATA_OUT, "oow_noeffect");

        // pin 0 routed to a nonexistent line
        wr(OFF_IRQ_ROUTE, 32'h03, 4'b0001);
        wr(OFF_IRQ_EN, 32'h1, 4'b0001);
        set_pads(m_pad | 16'h0001);
        rd_chk(OFF_IRQ_STATUS, "route3_status");
        check_irq("route3_irq");
        check("route3_irq0", 32'(irq), 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) set_pads(16'($urandom));
            else wr(5'(4 * $urandom_range(0, 7)), $urandom, 4'($urandom));
            rd_chk(5'(4 * $urandom_range(0, 7)), "rnd_rd");
            check_irq("rnd_irq");
        end

        // reset in the middle of an acked write
        set_pads(16'h0);
        @(negedge clock);
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1;
        bus.wbs_adr_i = BASE + 32'(OFF_DATA_OUT); bus.wbs_dat_i = 32'h1234; bus.wbs_sel_i = 4'hF;
        @(posedge clock); #1;
        check("midrst_ack_before", 32'(bus.wbs_ack_o), 32'h1);
        reset_n = 1'b0;
        #1;
        check("midrst_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("midrst_io_out", 32'(io_out), 32'h0);
        check("midrst_io_oeb", 32'(io_oeb), 32'h0000FFFF);
        check("midrst_irq", 32'(irq), 32'h0);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) rd_chk(5'(4 * i), "post_rst_rd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
